if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage plus the IF/ID pipeline register of the pipelined MIPS32 core. It owns the program counter and drives the instruction-memory address. It latches the fetched word and its address into IF/ID for the decode stage, which consumes `Instr` and `PC_ID`. It handles load-use stalls from the hazard unit, branch/jump redirects with flush, and a HLT-driven halt state machine.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000: word inserted into IF/ID on flush or halt (`sll $0,$0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard-unit freeze; PC and IF/ID hold.
- `redirect_valid`  in  1  taken branch or jump resolved downstream; load PC and flush IF/ID.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored and forced to 00.
- `imem_addr`  out  32  instruction-memory address, equal to the current PC.
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`.
- `Instr`  out  32  IF/ID instruction to decode.
- `PC_ID`  out  32  IF/ID address of `Instr`.
- `PC4_ID`  out  32  IF/ID `PC_ID + 4`.
- `valid_ID`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch FSM is in HALTED.
- `fetch_count`  out  32  number of valid instructions latched into IF/ID.

## Operation
- PC register drives `imem_addr` directly. `imem_addr[1:0]` is always 00.
- Per-edge priority, highest first:
  1. Reset.
  2. `redirect_valid`.
  3. `stall`.
  4. Normal fetch.
- Redirect:
  - PC <= {`redirect_pc[31:2]`, 2'b00}.
  - IF/ID <= {`NOP_INSTR`, PC_ID=0, PC4_ID=0, valid 0}.
  - FSM -> RUN.
  - Redirect overrides a simultaneous `stall`.
- Stall, no redirect: PC, IF/ID, FSM and `fetch_count` all hold.
- Normal fetch in RUN:
  - IF/ID <= {`imem_rdata`, PC, PC+4, valid 1}.
  - `fetch_count` += 1.
  - If `imem_rdata[31:26]` == HLT opcode (6'h3F): PC holds and FSM -> HALTED. Otherwise PC <= PC+4.
- HALTED with no stall and no redirect: IF/ID <= NOP bubble (valid 0); PC holds; `fetch_count` holds.
- FSM states:
  - RUN -> HALTED: on fetching HLT.
  - HALTED -> RUN: only on `redirect_valid` (the HLT was on a mispredicted path).
  - No other transitions.
- Arithmetic:
  - PC+4 is 32-bit and wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
  - `fetch_count` wraps at 2^32.
- `halted` = (state == HALTED), registered.

## Timing
- Reset (async assert, sync release via the first edge after deassert):
  - PC = `RESET_PC`.
  - `Instr` = `NOP_INSTR`.
  - `PC_ID` = 0, `PC4_ID` = 0.
  - `valid_ID` = 0, `halted` = 0, `fetch_count` = 0.
  - FSM = RUN.
- Reset asserted mid-operation clears all state immediately, regardless of stall, redirect or halt.
- Latency:
  - Instruction at PC appears on `Instr` one edge after PC is presented.
  - First valid IF/ID entry appears on the first edge after `rst_n` deasserts.
- Redirect penalty: the instruction fetched in the redirect cycle is discarded, giving one bubble. The target word is valid in IF/ID two edges after `redirect_valid`.
- Stall may be held any number of cycles. Outputs are bit-stable throughout.
- An HLT sits in IF/ID with `valid_ID` = 1 for one cycle (longer if stalled). It is followed by bubbles.

## Structure
- Shared package `mips_pkg`: `OPC_HLT` (6'h3F), `NOP_INSTR`, `RESET_PC_DEFAULT`, and fetch-state encoding (`FS_RUN` = 1'b0, `FS_HALTED` = 1'b1).
- One sub-module: `if_id_reg`, the IF/ID register with load/hold/flush controls and async active-low reset.
- PC, next-PC mux and FSM live in `if_stage` itself.

## Test plan
- Reset then free run; imem holds 0x20010005, 0x20020003, 0x00221820 at 0x0, 0x4, 0x8 -> `Instr`/`PC_ID` sequence matches at 0x0, 0x4, 0x8 on successive edges; `fetch_count` reaches 3.
- `stall` high for 3 cycles while `PC_ID` = 0x4 -> `Instr`, `PC_ID` and `imem_addr` (0x8) unchanged for 3 cycles; resume yields `PC_ID` = 0x8.
- `redirect_valid` with `redirect_pc` = 0x43 while `stall` = 1 -> next edge gives `valid_ID` = 0, `Instr` = NOP, `imem_addr` = 0x40; following edge gives `PC_ID` = 0x40.
- HLT (0xFC000000) at 0xC -> `PC_ID` = 0xC with valid 1, then `halted` = 1, `imem_addr` stays 0xC, bubbles follow and `fetch_count` frozen; redirect to 0x100 -> `halted` = 0, fetch resumes at 0x100.
- `rst_n` pulsed low mid-stream at PC 0x20 -> all outputs take reset values immediately, without waiting for a clock edge.
- `RESET_PC` = 32'hFFFF_FFFC -> second fetch address is 0x0 (wrap), with no error.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 core types and constants for the fetch path.
// Holds no logic, so it has no latency and no backpressure behaviour.
package mips_pkg;

    localparam logic [5:0]  OPC_HLT          = 6'h3F;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    // One IF/ID pipeline entry as seen by decode.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        vld;
    } ifid_t;

    function automatic ifid_t ifid_bubble(input logic [31:0] nop_word);
        ifid_t b;
        b.instr = nop_word;
        b.pc    = '0;
        b.pc4   = '0;
        b.vld   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, imem port and IF/ID outputs.
// Pure wiring; no latency and no backpressure of its own.
interface if_stage_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC_ID;
    logic [31:0] PC4_ID;
    logic        valid_ID;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, Instr, PC_ID, PC4_ID, valid_ID, halted, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, Instr, PC_ID, PC4_ID, valid_ID, halted, fetch_count
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush > load > hold priority.
// One edge from d to q; hold (neither load nor flush) freezes the entry for stalls.
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_INSTR
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           flush,
    input  mips_pkg::ifid_t d,
    output mips_pkg::ifid_t q
);
    import mips_pkg::*;

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d = ifid_bubble(NOP_WORD);
        end else if (load) begin
            ifid_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= ifid_bubble(NOP_WORD);
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, next-PC select, HLT fetch FSM and the IF/ID register.
// Fetched word lands in IF/ID one edge after its PC; stall freezes PC, IF/ID, FSM and count.
module if_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic      clk,
    input  logic      rst_n,
    if_stage_if.master bus
);
    import mips_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  pc_plus4;
    logic         ifid_load;
    logic         ifid_flush;
    ifid_t        ifid_d;
    ifid_t        ifid_q;
    logic         unused_rpc_lsb;

    assign pc_plus4       = pc_q + 32'd4;
    assign unused_rpc_lsb = ^bus.redirect_pc[1:0];

    always_comb begin
        ifid_d.instr = bus.imem_rdata;
        ifid_d.pc    = pc_q;
        ifid_d.pc4   = pc_plus4;
        ifid_d.vld   = 1'b1;
    end

    // Redirect beats stall; a halted fetch keeps pushing bubbles until redirected.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        if (bus.redirect_valid) begin
            pc_d       = {bus.redirect_pc[31:2], 2'b00};
            state_d    = FS_RUN;
            ifid_flush = 1'b1;
        end else if (bus.stall) begin
            state_d = state_q;
        end else if (state_q == FS_RUN) begin
            ifid_load     = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
            if (bus.imem_rdata[31:26] == OPC_HLT) begin
                state_d = FS_HALTED;
            end else begin
                pc_d = pc_plus4;
            end
        end else begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FS_RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.Instr       = ifid_q.instr;
    assign bus.PC_ID       = ifid_q.pc;
    assign bus.PC4_ID      = ifid_q.pc4;
    assign bus.valid_ID    = ifid_q.vld;
    assign bus.halted      = (state_q == FS_HALTED);
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: a reference fetch model pushes expected IF/ID state per edge.
// Second instance covers the RESET_PC wrap case.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_id;
        logic [31:0] pc4;
        logic        vld;
        logic        halted;
        logic [31:0] cnt;
        logic [31:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic [31:0] m_pc, m_cnt, m_instr, m_pcid, m_pc4;
    logic        m_halt, m_vld;

    if_stage_if bus_a ();
    if_stage_if bus_b ();

    if_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    if_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h2002_0003;
            32'h0000_0008: return 32'h0022_1820;
            32'h0000_000C: return 32'hFC00_0000;
            default:       return {6'h08, 10'h000, a[15:0]};
        endcase
    endfunction

    assign bus_a.imem_rdata = imem_word(bus_a.imem_addr);
    assign bus_b.imem_rdata = imem_word(bus_b.imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        m_halt  = 1'b0;
        m_instr = NOP;
        m_pcid  = 32'h0;
        m_pc4   = 32'h0;
        m_vld   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".instr"},  bus_a.Instr,       NOP);
        check_eq({tag, ".pc_id"},  bus_a.PC_ID,       32'h0);
        check_eq({tag, ".pc4"},    bus_a.PC4_ID,      32'h0);
        check_eq({tag, ".valid"},  {31'h0, bus_a.valid_ID}, 32'h0);
        check_eq({tag, ".halted"}, {31'h0, bus_a.halted},   32'h0);
        check_eq({tag, ".count"},  bus_a.fetch_count, 32'h0);
        check_eq({tag, ".addr"},   bus_a.imem_addr,   32'h0);
    endtask

    // Drive one cycle of controls from a negedge, predict the edge, then compare after it.
    task automatic cycle(input logic s, input logic rv, input logic [31:0] rpc);
        exp_t        e;
        logic [31:0] w;
        bus_a.stall          = s;
        bus_a.redirect_valid = rv;
        bus_a.redirect_pc    = rpc;
        if (rv) begin
            m_pc    = {rpc[31:2], 2'b00};
            m_halt  = 1'b0;
            m_instr = NOP;
            m_pcid  = 32'h0;
            m_pc4   = 32'h0;
            m_vld   = 1'b0;
        end else if (s) begin
            m_vld = m_vld;
        end else if (!m_halt) begin
            w       = imem_word(m_pc);
            m_instr = w;
            m_pcid  = m_pc;
            m_pc4   = m_pc + 32'd4;
            m_vld   = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            if (w[31:26] == 6'h3F) m_halt = 1'b1;
            else                   m_pc   = m_pc + 32'd4;
        end else begin
            m_instr = NOP;
            m_pcid  = 32'h0;
            m_pc4   = 32'h0;
            m_vld   = 1'b0;
        end
        e.instr  = m_instr;
        e.pc_id  = m_pcid;
        e.pc4    = m_pc4;
        e.vld    = m_vld;
        e.halted = m_halt;
        e.cnt    = m_cnt;
        e.addr   = m_pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            check_eq("instr",  bus_a.Instr,       e.instr);
            check_eq("pc_id",  bus_a.PC_ID,       e.pc_id);
            check_eq("pc4_id", bus_a.PC4_ID,      e.pc4);
            check_eq("valid",  {31'h0, bus_a.valid_ID}, {31'h0, e.vld});
            check_eq("halted", {31'h0, bus_a.halted},   {31'h0, e.halted});
            check_eq("count",  bus_a.fetch_count, e.cnt);
            check_eq("addr",   bus_a.imem_addr,   e.addr);
        end
        @(negedge clk);
    endtask

    initial begin
        bus_a.stall          = 1'b0;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = 32'h0;
        bus_b.stall          = 1'b0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = 32'h0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        check_eq("wrap.reset_addr", bus_b.imem_addr, 32'hFFFF_FFFC);

        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        check_eq("wrap.pc_id", bus_b.PC_ID,     32'hFFFF_FFFC);
        check_eq("wrap.pc4",   bus_b.PC4_ID,    32'h0);
        check_eq("wrap.addr",  bus_b.imem_addr, 32'h0);
        check_eq("wrap.valid", {31'h0, bus_b.valid_ID}, 32'h1);

        cycle(1'b0, 1'b0, 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        repeat (2) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);

        cycle(1'b0, 1'b1, 32'h0000_0100);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        cycle(1'b1, 1'b1, 32'h0000_0043);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        cycle(1'b0, 1'b1, 32'h0000_0018);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check_eq("pre_rst.addr", bus_a.imem_addr, 32'h0000_0020);

        bus_a.stall          = 1'b1;
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h0000_0200;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        @(posedge clk);
        #1;
        check_reset("mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
